spi_slave: RTL and testbench
============================

// Module: spi_slave
// PURPOSE
//  SPI mode-0 slave front end feeding the packet controller.
//  - Oversamples SCK, CS_N and MOSI in the system clock domain.
//  - Deframes MOSI into bytes, each delivered with a 1-cycle strobe.
//  - Serialises the controller's reply byte onto MISO.
//  - Pulses tsx_start at CS_N assertion so the controller can enter packet parsing.
// PARAMETERS
//  SYNC_STAGES  2  synchroniser flops on spi_sck/spi_cs_n/spi_mosi (>=2)
// PORTS
//  clk          in   1  system clock; single clock domain
//  rst_n        in   1  asynchronous, active-low reset
//  spi_sck      in   1  SPI clock from master, async; idle low (CPOL=0)
//  spi_cs_n     in   1  chip select from master, async, active low
//  spi_mosi     in   1  serial data from master, async, MSB first
//  spi_miso     out  1  serial data to master, MSB first
//  spi_miso_oe  out  1  MISO output enable; pad tristate lives at top level
//  rx_data      out  8  last complete received byte; to controller spi_c_data_in
//  rx_stb       out  1  1-cycle pulse: rx_data valid; to spi_c_data_stb
//  tsx_start    out  1  1-cycle pulse on CS_N assertion; to spi_tsx_start
//  tsx_end      out  1  1-cycle pulse on CS_N deassertion
//  tx_data      in   8  reply byte from controller spi_c_data_out
// BEHAVIOUR
//  Reset (rst_n=0, async):
//  - sync chains: sck=0, cs_n=1, mosi=0.
//  - rx_data=0, rx_stb=0, tsx_start=0, tsx_end=0.
//  - spi_miso=0, spi_miso_oe=0; shift regs=0, bit_cnt=0, state=IDLE.
//  Timing:
//  - All decisions use the synchronised signals plus a 1-flop delayed copy for edge detect.
//  - Required operating constraints: f_clk >= 16*f_sck; master holds CS_N low for at
//    least SYNC_STAGES+4 clk before the first SCK rise.
//  FSM states:
//  - IDLE: waits for a cs_n fall. On the fall: tsx_start=1 for one cycle, bit_cnt=0,
//    go LOAD.
//  - LOAD: one cycle. Lets the controller register its first reply byte (it updates
//    tx_data the cycle after tsx_start). Then tx_shift<=tx_data, go ACTIVE.
//  - ACTIVE, SCK rise: rx_shift<={rx_shift[6:0],mosi}; bit_cnt<=bit_cnt+1 (3-bit, wraps).
//    When bit_cnt==7 before the increment (8th bit):
//    - next cycle rx_data<={rx_shift[6:0],mosi} and rx_stb=1 for exactly one cycle.
//  - ACTIVE, SCK fall:
//    - bit_cnt==0 (byte boundary): tx_shift<=tx_data (reload).
//    - otherwise: tx_shift<={tx_shift[6:0],1'b0}.
//  - Any state, cs_n rise: tsx_end=1 for one cycle, go IDLE.
//    - Partial byte (bit_cnt!=0) is discarded; no rx_stb.
//  - IDLE, SCK edges: ignored.
//  Outputs:
//  - spi_miso = tx_shift[7] while state!=IDLE, else 0.
//  - spi_miso_oe = (state!=IDLE).
//  - rx_data holds its value until the next complete byte.
//  Strobe spacing guarantee:
//  - Consecutive rx_stb pulses are >=128 clk apart, always at least 2 low cycles between.
//  - tsx_start never coincides with rx_stb.
//  Corner cases:
//  - CS_N fall and rise in the same cycle window (glitch <SYNC_STAGES clk): may be
//    filtered. If seen, it produces tsx_start then tsx_end, never rx_stb.
//  - SCK edge in the same cycle as a cs_n rise: the cs_n rise wins; no shift, no stb.
//  - Reset mid-byte: everything returns to reset values immediately. First byte after
//    reset requires a fresh CS_N fall.
// TESTING
//  1. CS_N low, MOSI 8'h03, 8'h05 at f_sck=clk/16:
//     - tsx_start once; rx_stb twice with rx_data 03 then 05.
//     - MISO shifts A5 during byte 0 when tx_data=A5 is set the cycle after tsx_start.
//  2. Reply path: tx_data=8'h1F during byte 1 -> master samples 8'h1F on MISO in byte 2,
//     MSB first.
//  3. CS_N raised after 5 bits -> tsx_end pulse, no rx_stb, rx_data unchanged; next frame
//     restarts at bit 0.
//  4. rst_n pulsed low after bit 3 of byte -> rx_stb=0, miso_oe=0, state IDLE
//     asynchronously; next full frame with byte 8'hC3 -> rx_data=C3.
//  5. Back-to-back 32-byte frame at clk/16 -> 32 rx_stb pulses, each 128 clk apart;
//     no two within 3 cycles.
//  6. SCK toggling with CS_N high -> no rx_stb, no tsx_start, spi_miso_oe stays 0.

Source files
------------

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 slave front end with oversampled inputs, byte deframing and reply serialiser
module spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_sck,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic [7:0] rx_data,
    output logic       rx_stb,
    output logic       tsx_start,
    output logic       tsx_end,
    input  logic [7:0] tx_data
);
    typedef enum logic [1:0] {IDLE, LOAD, ACTIVE} state_t;
    state_t state_q, state_d;
    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d, cs_sync_q, cs_sync_d, mosi_sync_q, mosi_sync_d;
    logic sck_dly_q, sck_dly_d, cs_dly_q, cs_dly_d;
    logic sck_s, cs_s, mosi_s, sck_rise, sck_fall, cs_rise, cs_fall;
    logic [6:0] rx_shift_q, rx_shift_d;
    logic [7:0] tx_shift_q, tx_shift_d, rx_data_q, rx_data_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic rx_stb_q, rx_stb_d;
    // Synchroniser shift and edge detection against the delayed copies
    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        sck_s       = sck_sync_q[SYNC_STAGES-1];
        cs_s        = cs_sync_q[SYNC_STAGES-1];
        mosi_s      = mosi_sync_q[SYNC_STAGES-1];
        sck_dly_d   = sck_s;
        cs_dly_d    = cs_s;
        sck_rise    = sck_s & ~sck_dly_q;
        sck_fall    = ~sck_s & sck_dly_q;
        cs_rise     = cs_s & ~cs_dly_q;
        cs_fall     = ~cs_s & cs_dly_q;
    end
    // Synchroniser and edge-detect flops; chip select idles deasserted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_dly_q   <= 1'b0;
            cs_dly_q    <= 1'b1;
        end else begin
            sck_sync_q  <= sck_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sck_dly_q   <= sck_dly_d;
            cs_dly_q    <= cs_dly_d;
        end
    end
    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end
    // Next state: a chip-select release overrides everything else
    always_comb begin
        state_d = state_q;
        if (cs_rise) state_d = IDLE;
        else begin
            case (state_q)
                IDLE:    state_d = cs_fall ? LOAD : IDLE;
                LOAD:    state_d = ACTIVE;
                default: state_d = ACTIVE;
            endcase
        end
    end
    // Shift datapath: sample MOSI on SCK rise, advance MISO on SCK fall
    always_comb begin
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        bit_cnt_d  = bit_cnt_q;
        rx_data_d  = rx_data_q;
        rx_stb_d   = 1'b0;
        if (state_q == IDLE && cs_fall) bit_cnt_d = 3'd0;
        if (state_q == LOAD && !cs_rise) tx_shift_d = tx_data;
        if (state_q == ACTIVE && !cs_rise && sck_rise) begin
            rx_shift_d = {rx_shift_q[5:0], mosi_s};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            rx_stb_d   = (bit_cnt_q == 3'd7);
            rx_data_d  = (bit_cnt_q == 3'd7) ? {rx_shift_q, mosi_s} : rx_data_q;
        end
        if (state_q == ACTIVE && !cs_rise && sck_fall)
            tx_shift_d = (bit_cnt_q == 3'd0) ? tx_data : {tx_shift_q[6:0], 1'b0};
    end
    // Datapath flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            bit_cnt_q  <= '0;
            rx_data_q  <= '0;
            rx_stb_q   <= 1'b0;
        end else begin
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_data_q  <= rx_data_d;
            rx_stb_q   <= rx_stb_d;
        end
    end
    // Outputs: MISO driven only inside a transaction, frame pulses decoded from edge flops
    always_comb begin
        spi_miso_oe = (state_q != IDLE);
        spi_miso    = (state_q != IDLE) & tx_shift_q[7];
        tsx_start   = (state_q == IDLE) & cs_fall;
        tsx_end     = cs_rise;
        rx_data     = rx_data_q;
        rx_stb      = rx_stb_q;
    end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed checks of the SPI mode-0 slave front end
module tb_spi_slave;
    logic clk = 1'b0, rst_n = 1'b0, spi_sck = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
    logic spi_miso, spi_miso_oe, rx_stb, tsx_start, tsx_end;
    logic [7:0] rx_data, tx_data = 8'h00, mi;
    int n_assert = 0, n_fail = 0;
    int cyc = 0, stb_cnt = 0, start_cnt = 0, end_cnt = 0, oe_cnt = 0, dbl = 0, overlap = 0;
    logic prev_stb = 1'b0;
    int stb_cyc[$];

    spi_slave #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .rx_data(rx_data), .rx_stb(rx_stb),
        .tsx_start(tsx_start), .tsx_end(tsx_end), .tx_data(tx_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor sampled mid-cycle
    always @(negedge clk) begin
        if (rx_stb) begin
            stb_cnt++;
            stb_cyc.push_back(cyc);
            if (prev_stb) dbl++;
        end
        if (tsx_start) start_cnt++;
        if (tsx_start && rx_stb) overlap++;
        if (tsx_end) end_cnt++;
        if (spi_miso_oe) oe_cnt++;
        prev_stb = rx_stb;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input logic [7:0] first_tx);
        int k = 0;
        spi_cs_n = 1'b0;
        while (!tsx_start && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("tsx_start_seen", tsx_start, 1);
        @(posedge clk);
        #1 tx_data = first_tx;
    endtask

    task automatic end_frame();
        int k = 0;
        spi_cs_n = 1'b1;
        while (!tsx_end && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("tsx_end_seen", tsx_end, 1);
        repeat (4) @(negedge clk);
    endtask

    // Master shifts nbits MSB first; tx_data moves to nxt after the first rise of the byte
    task automatic xfer(input logic [7:0] mo, input logic [7:0] nxt, input int nbits, output logic [7:0] m);
        m = '0;
        for (int i = 7; i >= 8 - nbits; i--) begin
            spi_mosi = mo[i];
            repeat (8) @(negedge clk);
            spi_sck = 1'b1;
            m[i] = spi_miso;
            if (i == 7) tx_data = nxt;
            repeat (8) @(negedge clk);
            spi_sck = 1'b0;
        end
    endtask

    initial begin
        int s0, e0, o0, bad_gap, bad_rx, bad_mi;
        logic [7:0] mo, prev_mo;
        #2;
        check("rst_miso", spi_miso, 0);
        check("rst_oe", spi_miso_oe, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_stb", rx_stb, 0);
        check("rst_tsx_start", tsx_start, 0);
        check("rst_tsx_end", tsx_end, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_oe", spi_miso_oe, 0);

        // Frame: 03, 05, E7 with replies A5, 3C, 1F
        start_frame(8'hA5);
        xfer(8'h03, 8'h3C, 8, mi);
        check("b0_miso", mi, 8'hA5);
        check("b0_rx", rx_data, 8'h03);
        check("b0_oe", spi_miso_oe, 1);
        xfer(8'h05, 8'h1F, 8, mi);
        check("b1_miso", mi, 8'h3C);
        check("b1_rx", rx_data, 8'h05);
        xfer(8'hE7, 8'h00, 8, mi);
        check("b2_miso", mi, 8'h1F);
        check("b2_rx", rx_data, 8'hE7);
        end_frame();
        check("f1_stb_cnt", stb_cnt, 3);
        check("f1_start_cnt", start_cnt, 1);
        check("f1_end_cnt", end_cnt, 1);
        check("f1_oe_after", spi_miso_oe, 0);

        // Partial frame of 5 bits is discarded
        start_frame(8'h00);
        xfer(8'hFF, 8'h00, 5, mi);
        end_frame();
        check("part_stb_cnt", stb_cnt, 3);
        check("part_rx_hold", rx_data, 8'hE7);
        check("part_end_cnt", end_cnt, 2);
        start_frame(8'h5A);
        xfer(8'h96, 8'h00, 8, mi);
        check("restart_miso", mi, 8'h5A);
        check("restart_rx", rx_data, 8'h96);
        end_frame();
        check("restart_stb_cnt", stb_cnt, 4);

        // Reset after bit 3 of a byte
        start_frame(8'hFF);
        xfer(8'hC3, 8'hFF, 3, mi);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_oe", spi_miso_oe, 0);
        check("mid_rst_stb", rx_stb, 0);
        check("mid_rst_miso", spi_miso, 0);
        check("mid_rst_rx", rx_data, 0);
        spi_cs_n = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_oe", spi_miso_oe, 0);
        check("post_rst_stb_cnt", stb_cnt, 4);
        start_frame(8'h00);
        xfer(8'hC3, 8'h00, 8, mi);
        end_frame();
        check("post_rst_rx", rx_data, 8'hC3);
        check("post_rst_stb_cnt2", stb_cnt, 5);

        // 32-byte back-to-back frame; reply for byte i is the complement of byte i-1
        s0 = stb_cnt;
        bad_rx = 0;
        bad_mi = 0;
        prev_mo = 8'h00;
        start_frame(8'h00);
        for (int i = 0; i < 32; i++) begin
            mo = 8'(i * 37 + 5);
            xfer(mo, ~mo, 8, mi);
            if (rx_data !== mo) bad_rx++;
            if (mi !== (i == 0 ? 8'h00 : ~prev_mo)) bad_mi++;
            prev_mo = mo;
        end
        end_frame();
        check("burst_stb_cnt", stb_cnt - s0, 32);
        check("burst_rx_bad", bad_rx, 0);
        check("burst_miso_bad", bad_mi, 0);
        bad_gap = 0;
        for (int i = s0 + 1; i < stb_cnt; i++)
            if (stb_cyc[i] - stb_cyc[i-1] != 128) bad_gap++;
        check("burst_gap_bad", bad_gap, 0);
        check("stb_width", dbl, 0);
        check("start_stb_overlap", overlap, 0);

        // SCK activity with CS_N high is ignored
        s0 = stb_cnt;
        e0 = end_cnt;
        o0 = oe_cnt;
        for (int i = 0; i < 12; i++) begin
            spi_mosi = i[0];
            spi_sck = 1'b1;
            repeat (8) @(negedge clk);
            spi_sck = 1'b0;
            repeat (8) @(negedge clk);
        end
        check("cs_high_stb", stb_cnt - s0, 0);
        check("cs_high_start", start_cnt, 6);
        check("cs_high_end", end_cnt - e0, 0);
        check("cs_high_oe", oe_cnt - o0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
